// File: rtl/input_cond_pkg.sv
// Shared definitions for the a/b input conditioner.
// Contents:
//   DEFAULT_SYNC_STAGES, DEFAULT_DEBOUNCE_CYCLES - parameter defaults
//   edge_evt_t  - packed {rise, fall} edge-event pair
//   edge_detect - builds an edge_evt_t from the current and next level
package input_cond_pkg;

   localparam int DEFAULT_SYNC_STAGES     = 2;
   localparam int DEFAULT_DEBOUNCE_CYCLES = 16;

   typedef struct packed {
      logic rise;
      logic fall;
   } edge_evt_t;

   // Evaluated on the next-state level, so the pulse lands on the same edge as the level change
   function automatic edge_evt_t edge_detect(input logic prev, input logic nxt);
      edge_evt_t evt;
      evt.rise = nxt & ~prev;
      evt.fall = ~nxt & prev;
      return evt;
   endfunction

endpackage

// File: rtl/debounce_channel.sv
// Single-bit synchroniser + debouncer with registered edge pulses.
// Ports:
//   clk       - system clock, rising edge
//   rst_n     - asynchronous active-low reset
//   raw       - asynchronous raw pin
//   level     - debounced level (registered)
//   level_nxt - value level takes on the next edge (for aligned downstream registers)
//   rise/fall - one-cycle pulses on the first cycle level shows its new value
module debounce_channel
   import input_cond_pkg::*;
#(
   parameter int SYNC_STAGES     = DEFAULT_SYNC_STAGES,
   parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
   input  logic clk,
   input  logic rst_n,
   input  logic raw,
   output logic level,
   output logic level_nxt,
   output logic rise,
   output logic fall
);

   localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

   if (SYNC_STAGES < 2 || DEBOUNCE_CYCLES < 1) begin : g_param_check
      $error("debounce_channel: SYNC_STAGES must be >= 2 and DEBOUNCE_CYCLES >= 1");
   end

   logic [SYNC_STAGES-1:0] sync_r;
   logic                   sync_s;
   logic [CNT_W-1:0]       cnt_r;
   logic [CNT_W-1:0]       cnt_nxt_s;
   logic                   level_r;
   logic                   level_nxt_s;
   edge_evt_t              evt_r;

   assign sync_s = sync_r[SYNC_STAGES-1];

   // Synchroniser chain: plain shift, nothing between the flops
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_r <= '0;
      end else begin
         sync_r <= {sync_r[SYNC_STAGES-2:0], raw};
      end
   end

   // Debounce next state: any match clears the count, a full run of mismatches flips the level
   always_comb begin
      cnt_nxt_s   = cnt_r;
      level_nxt_s = level_r;
      if (sync_s == level_r) begin
         cnt_nxt_s = '0;
      end else if (cnt_r == CNT_MAX) begin
         level_nxt_s = sync_s;
         cnt_nxt_s   = '0;
      end else begin
         cnt_nxt_s = cnt_r + CNT_W'(1);
      end
   end

   // Level, counter and edge-pulse registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_r   <= '0;
         level_r <= 1'b0;
         evt_r   <= '0;
      end else begin
         cnt_r   <= cnt_nxt_s;
         level_r <= level_nxt_s;
         evt_r   <= edge_detect(level_r, level_nxt_s);
      end
   end

   assign level     = level_r;
   assign level_nxt = level_nxt_s;
   assign rise      = evt_r.rise;
   assign fall      = evt_r.fall;

endmodule

// File: rtl/ab_input_conditioner.sv
// Conditions the two raw pins feeding main.a / main.b: synchronise, debounce,
// and provide one-cycle edge pulses plus a registered a AND b.
// Ports:
//   clk, rst_n        - clock (rising edge), asynchronous active-low reset
//   a_raw, b_raw      - asynchronous raw pins
//   a, b              - debounced levels, to main.a / main.b
//   a_rise, a_fall    - channel A edge pulses
//   b_rise, b_fall    - channel B edge pulses
//   both_hi           - registered a AND b, changes on the same edge as a/b
module ab_input_conditioner
   import input_cond_pkg::*;
#(
   parameter int SYNC_STAGES     = DEFAULT_SYNC_STAGES,
   parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
   input  logic clk,
   input  logic rst_n,
   input  logic a_raw,
   input  logic b_raw,
   output logic a,
   output logic b,
   output logic a_rise,
   output logic a_fall,
   output logic b_rise,
   output logic b_fall,
   output logic both_hi
);

   logic a_nxt_s;
   logic b_nxt_s;
   logic both_hi_r;

   debounce_channel #(
      .SYNC_STAGES     (SYNC_STAGES),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
   ) u_a (
      .clk       (clk),
      .rst_n     (rst_n),
      .raw       (a_raw),
      .level     (a),
      .level_nxt (a_nxt_s),
      .rise      (a_rise),
      .fall      (a_fall)
   );

   debounce_channel #(
      .SYNC_STAGES     (SYNC_STAGES),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
   ) u_b (
      .clk       (clk),
      .rst_n     (rst_n),
      .raw       (b_raw),
      .level     (b),
      .level_nxt (b_nxt_s),
      .rise      (b_rise),
      .fall      (b_fall)
   );

   // both_hi built from next-state levels so it is never a cycle behind a/b
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         both_hi_r <= 1'b0;
      end else begin
         both_hi_r <= a_nxt_s & b_nxt_s;
      end
   end

   assign both_hi = both_hi_r;

endmodule
